// File: rtl/rv32_branch_predictor.sv
// -----------------------------------------------------------------------------
// rv32_branch_predictor
//   Fetch-side direction predictor (2-bit saturating counters) with a
//   direct-mapped branch target buffer. Lookup is combinational from
//   registered state; training comes from the exec stage's resolved outcome.
//
// Ports
//   clk              core clock, rising edge
//   rst              asynchronous active-high reset
//   fetch_pc         PC being fetched this cycle
//   pred_taken       predicted taken for fetch_pc
//   pred_target      predicted next PC (BTB target or fetch_pc+4)
//   upd_valid        exec resolved a branch/jump this cycle
//   upd_pc           PC of the resolved instruction
//   upd_taken        resolved direction (do_branch)
//   upd_target       resolved taken target
//   upd_is_jump      resolved instruction is an unconditional jump
//   upd_mispredict   fetch prediction for this instruction was wrong
//   perf_branches    saturating count of resolved branches/jumps
//   perf_mispredicts saturating count of mispredictions
// -----------------------------------------------------------------------------
module rv32_branch_predictor #(
    parameter int ENTRIES  = 64,
    parameter int TAG_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_is_jump,
    input  logic        upd_mispredict,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
);

    localparam int IDX_BITS = $clog2(ENTRIES);

    typedef enum logic [1:0] {
        CTR_STRONG_NT = 2'b00,
        CTR_WEAK_NT   = 2'b01,
        CTR_WEAK_T    = 2'b10,
        CTR_STRONG_T  = 2'b11
    } ctr_e;

    // Per-entry state
    logic                valid_q  [ENTRIES];
    ctr_e                ctr_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_mem  [ENTRIES];
    logic [31:0]         tgt_mem  [ENTRIES];

    // Index / tag extraction; pc[1:0] and bits above the tag are ignored
    logic [IDX_BITS-1:0] f_idx, u_idx;
    logic [TAG_BITS-1:0] f_tag, u_tag;

    assign f_idx = fetch_pc[IDX_BITS+1:2];
    assign f_tag = fetch_pc[IDX_BITS+2 +: TAG_BITS];
    assign u_idx = upd_pc[IDX_BITS+1:2];
    assign u_tag = upd_pc[IDX_BITS+2 +: TAG_BITS];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc, upd_pc};

    // -------------------------------------------------------------------------
    // Lookup: reads pre-update state, so a same-cycle update to the same entry
    // becomes visible only on the following cycle.
    // -------------------------------------------------------------------------
    logic f_hit;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        f_hit       = 1'b0;
        pred_taken  = 1'b0;
        pred_target = fetch_pc + 32'd4;
        f_hit       = valid_q[f_idx] && (tag_mem[f_idx] == f_tag);
        pred_taken  = f_hit && ctr_q[f_idx][1];
        if (pred_taken) begin
            pred_target = tgt_mem[f_idx];
        end
    end

    // -------------------------------------------------------------------------
    // Update: valid bits, counters and perf counters carry reset
    // -------------------------------------------------------------------------
    logic u_hit;
    assign u_hit = valid_q[u_idx] && (tag_mem[u_idx] == u_tag);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is assigned with non-blocking (<=) so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WEAK_NT;
            end
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (upd_valid) begin
            if (u_hit) begin
                if (upd_is_jump) begin
                    ctr_q[u_idx] <= CTR_STRONG_T;
                end else if (upd_taken) begin
                    if (ctr_q[u_idx] != CTR_STRONG_T)
                        ctr_q[u_idx] <= ctr_e'(ctr_q[u_idx] + 2'd1);
                end else begin
                    if (ctr_q[u_idx] != CTR_STRONG_NT)
                        ctr_q[u_idx] <= ctr_e'(ctr_q[u_idx] - 2'd1);
                end
            end else if (upd_taken) begin
                // Allocate by overwriting whatever occupied the slot
                valid_q[u_idx] <= 1'b1;
                ctr_q[u_idx]   <= upd_is_jump ? CTR_STRONG_T : CTR_WEAK_T;
            end

            if (perf_branches != 32'hFFFF_FFFF)
                perf_branches <= perf_branches + 32'd1;
            if (upd_mispredict && (perf_mispredicts != 32'hFFFF_FFFF))
                perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Tag/target arrays: a taken outcome always writes both, which covers the
    // hit case (tag unchanged, target refreshed) and the allocate case.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: tag/target storage has no reset; its contents are meaningless
        // until the entry's valid bit is set, so it can map to plain RAM.
        if (!rst && upd_valid && upd_taken) begin
            tag_mem[u_idx] <= u_tag;
            tgt_mem[u_idx] <= upd_target;
        end
    end

endmodule
